// File: rtl/network_div_div_30s_16s_15_seq.sv
// network_div_div_30s_16s_15_seq
//   Sequential signed divider: 30-bit signed dividend / 16-bit signed divisor
//   -> 15-bit signed saturated quotient. Radix-2 restoring, one quotient bit
//   per ce-high cycle, truncation toward zero (C semantics).
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   ce              clock enable; low freezes every register
//   din_valid/ready operand handshake (din0 dividend, din1 divisor)
//   dout_valid/ready result handshake (dout quotient, ovf saturated, dbz /0)
//   rem             signed remainder, only with NETWORK_DIV_REMAINDER_EN
//
// Handshake: a transfer happens on a rising edge where valid & ready & ce are
// all high. din_ready is high only in IDLE; dout_valid is high only in HOLD,
// and the result is held there until it is taken. Operands and results never
// overlap, so din0/din1 may change freely after acceptance.
//
// Optional feature macro: NETWORK_DIV_REMAINDER_EN (adds the rem output).
module network_div_div_30s_16s_15_seq #(
    parameter int DIVIDEND_WIDTH = 30,
    parameter int DIVISOR_WIDTH  = 16,
    parameter int QUOTIENT_WIDTH = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [QUOTIENT_WIDTH-1:0] dout,
    output logic                      ovf,
    output logic                      dbz
`ifdef NETWORK_DIV_REMAINDER_EN
    ,
    output logic [DIVISOR_WIDTH-1:0]  rem
`endif
);

    localparam int DW = DIVIDEND_WIDTH;
    localparam int SW = DIVISOR_WIDTH;
    localparam int QW = QUOTIENT_WIDTH;
    localparam int CW = $clog2(DW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    // Largest quotient magnitudes representable for each result sign.
    localparam logic [DW-1:0] QPOS_MAG = DW'((2 ** (QW - 1)) - 1);
    localparam logic [DW-1:0] QNEG_MAG = DW'(2 ** (QW - 1));
    localparam logic [QW-1:0] QMAX     = {1'b0, {(QW - 1){1'b1}}};
    localparam logic [QW-1:0] QMIN     = {1'b1, {(QW - 1){1'b0}}};

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    // dvd starts as |dividend| and is shifted left each step; quotient bits
    // enter at the LSB, so after DW steps it holds the quotient magnitude.
    logic [DW-1:0] dvd;
    logic [SW-1:0] dsr;
    logic [SW-1:0] rem_r;
    logic          sgn_q;
    logic          neg_dvd;
    logic          dbz_r;

    logic [DW-1:0] a_mag;
    logic [SW-1:0] b_mag;
    logic [SW:0]   rem_shift;
    logic          ge;
    logic [SW-1:0] rem_sub;

    always_comb begin
        a_mag     = din0[DW-1] ? -din0 : din0;
        b_mag     = din1[SW-1] ? -din1 : din1;
        rem_shift = {rem_r, dvd[DW-1]};
        ge        = rem_shift >= {1'b0, dsr};
        // When ge holds the difference is below |divisor| <= 2^(SW-1), so the
        // low SW bits of the subtraction are exact.
        rem_sub   = rem_shift[SW-1:0] - dsr;
    end

    assign din_ready  = (state == IDLE);
    assign dout_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dvd     <= '0;
            dsr     <= '0;
            rem_r   <= '0;
            sgn_q   <= 1'b0;
            neg_dvd <= 1'b0;
            dbz_r   <= 1'b0;
            dout    <= '0;
            ovf     <= 1'b0;
            dbz     <= 1'b0;
`ifdef NETWORK_DIV_REMAINDER_EN
            rem     <= '0;
`endif
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        sgn_q   <= din0[DW-1] ^ din1[SW-1];
                        neg_dvd <= din0[DW-1];
                        dvd     <= a_mag;
                        dsr     <= b_mag;
                        rem_r   <= '0;
                        dbz_r   <= (din1 == '0);
                        cnt     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    // With a zero divisor every step "subtracts" zero, so
                    // rem_r ends up holding the low SW bits of |dividend|;
                    // re-signing that reproduces din0[SW-1:0] for rem.
                    rem_r <= ge ? rem_sub : rem_shift[SW-1:0];
                    dvd   <= {dvd[DW-2:0], ge};
                    cnt   <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    dbz <= dbz_r;
                    if (dbz_r) begin
                        dout <= neg_dvd ? QMIN : QMAX;
                        ovf  <= 1'b0;
                    end else if (sgn_q) begin
                        if (dvd > QNEG_MAG) begin
                            dout <= QMIN;
                            ovf  <= 1'b1;
                        end else begin
                            dout <= -dvd[QW-1:0];
                            ovf  <= 1'b0;
                        end
                    end else begin
                        if (dvd > QPOS_MAG) begin
                            dout <= QMAX;
                            ovf  <= 1'b1;
                        end else begin
                            dout <= dvd[QW-1:0];
                            ovf  <= 1'b0;
                        end
                    end
`ifdef NETWORK_DIV_REMAINDER_EN
                    rem <= neg_dvd ? -rem_r : rem_r;
`endif
                    state <= HOLD;
                end
                HOLD: begin
                    if (dout_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_network_div_div_30s_16s_15_seq.sv
// Testbench for network_div_div_30s_16s_15_seq: directed vector table,
// randomized operands against an integer-arithmetic reference, and
// hand-written sequences for backpressure, ce stalls and mid-operation reset.
module tb_network_div_div_30s_16s_15_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        din_valid;
    logic        din_ready;
    logic [29:0] din0;
    logic [15:0] din1;
    logic        dout_valid;
    logic        dout_ready;
    logic [14:0] dout;
    logic        ovf;
    logic        dbz;
`ifdef NETWORK_DIV_REMAINDER_EN
    logic [15:0] rem;
`endif

    int checks = 0;
    int errors = 0;

    network_div_div_30s_16s_15_seq dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din0       (din0),
        .din1       (din1),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .ovf        (ovf),
        .dbz        (dbz)
`ifdef NETWORK_DIV_REMAINDER_EN
        ,
        .rem        (rem)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint a;
        longint b;
        longint q;
        longint o;
        longint z;
        longint r;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain signed integer division, then the saturation rules.
    task automatic model(input longint a, input longint b, output longint q,
                         output longint o, output longint z, output longint r);
        logic [15:0] lo;
        if (b == 0) begin
            lo = 16'(a);
            q  = (a < 0) ? -16384 : 16383;
            o  = 0;
            z  = 1;
            r  = longint'($signed(lo));
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
            o = 0;
            if (q > 16383) begin
                q = 16383;
                o = 1;
            end else if (q < -16384) begin
                q = -16384;
                o = 1;
            end
        end
    endtask

    // Run one operation; rdly extra cycles of dout_ready=0 after dout_valid.
    task automatic do_op(input logic [29:0] a, input logic [15:0] b, input int rdly,
                         output longint q, output longint o, output longint z,
                         output longint r, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!din_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        din0       = a;
        din1       = b;
        din_valid  = 1'b1;
        dout_ready = (rdly == 0);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        din0      = 30'($urandom);
        din1      = 16'($urandom);
        lat = 0;
        while (!dout_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        q = longint'($signed(dout));
        o = longint'(ovf);
        z = longint'(dbz);
`ifdef NETWORK_DIV_REMAINDER_EN
        r = longint'($signed(rem));
`else
        r = 0;
`endif
        repeat (rdly) @(negedge clk);
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("accept_valid_low", longint'(dout_valid), 0);
        chk("accept_din_ready", longint'(din_ready), 1);
        dout_ready = 1'b0;
    endtask

    initial begin
        longint q, o, z, r;
        longint eq, eo, ez, er;
        int lat;
        int spur;
        logic signed [29:0] ra;
        logic signed [15:0] rb;

        vecs.push_back('{1000000, 100, 10000, 0, 0, 0});
        vecs.push_back('{-7, 2, -3, 0, 0, -1});
        vecs.push_back('{7, -2, -3, 0, 0, 1});
        vecs.push_back('{-7, -2, 3, 0, 0, -1});
        vecs.push_back('{0, 5, 0, 0, 0, 0});
        vecs.push_back('{536870911, 1, 16383, 1, 0, 0});
        vecs.push_back('{-536870912, 1, -16384, 1, 0, 0});
        vecs.push_back('{-536870912, -1, 16383, 1, 0, 0});
        vecs.push_back('{5, 0, 16383, 0, 1, 5});
        vecs.push_back('{-5, 0, -16384, 0, 1, -5});
        vecs.push_back('{100, 7, 14, 0, 0, 2});
        vecs.push_back('{16384, -1, -16384, 0, 0, 0});
        vecs.push_back('{16384, 1, 16383, 1, 0, 0});
        vecs.push_back('{-16384, 1, -16384, 0, 0, 0});
        vecs.push_back('{1000000, -32768, -30, 0, 0, 16960});
        vecs.push_back('{0, 0, 16383, 0, 1, 0});
        vecs.push_back('{-1, -32768, 0, 0, 0, -1});

        // reset block
        reset      = 1'b1;
        ce         = 1'b1;
        din_valid  = 1'b0;
        din0       = '0;
        din1       = '0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_din_ready", longint'(din_ready), 1);
        chk("rst_dout_valid", longint'(dout_valid), 0);
        chk("rst_dout", longint'(dout), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_dbz", longint'(dbz), 0);
`ifdef NETWORK_DIV_REMAINDER_EN
        chk("rst_rem", longint'(rem), 0);
`endif
        reset = 1'b0;

        // directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            do_op(30'(vecs[i].a), 16'(vecs[i].b), 0, q, o, z, r, lat);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_ovf", i), o, vecs[i].o);
            chk($sformatf("vec%0d_dbz", i), z, vecs[i].z);
            chk($sformatf("vec%0d_lat", i), longint'(lat), 31);
`ifdef NETWORK_DIV_REMAINDER_EN
            chk($sformatf("vec%0d_rem", i), r, vecs[i].r);
`endif
        end

        // randomized operands
        for (int i = 0; i < 150; i++) begin
            ra = 30'($urandom);
            ra = ra >>> $urandom_range(0, 29);
            rb = 16'($urandom);
            rb = rb >>> $urandom_range(0, 15);
            if ($urandom_range(0, 15) == 0) rb = '0;
            model(longint'(ra), longint'(rb), eq, eo, ez, er);
            do_op(ra, rb, $urandom_range(0, 3), q, o, z, r, lat);
            chk("rnd_q", q, eq);
            chk("rnd_ovf", o, eo);
            chk("rnd_dbz", z, ez);
            chk("rnd_lat", longint'(lat), 31);
`ifdef NETWORK_DIV_REMAINDER_EN
            chk("rnd_rem", r, er);
`endif
        end

        // backpressure: result held, new operands ignored
        @(negedge clk);
        din0       = 30'd1000000;
        din1       = 16'd100;
        din_valid  = 1'b1;
        dout_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!dout_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("bp_lat", longint'(lat), 31);
        din0 = 30'd77;
        din1 = 16'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid_held", longint'(dout_valid), 1);
            chk("bp_dout_held", longint'($signed(dout)), 10000);
            chk("bp_din_ready", longint'(din_ready), 0);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        ce         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_ce_low_hold", longint'(dout_valid), 1);
        ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", longint'(dout_valid), 0);
        chk("bp_release_ready", longint'(din_ready), 1);
        chk("bp_dout_retained", longint'($signed(dout)), 10000);
        dout_ready = 1'b0;
        spur = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (dout_valid || !din_ready) spur++;
        end
        chk("bp_back_idle", longint'(spur), 0);

        // ce low for 5 cycles mid-CALC
        din0       = 30'd1000000;
        din1       = 16'd100;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        lat = 0;
        while (!dout_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 10) ce = 1'b0;
            if (lat == 15) ce = 1'b1;
        end
        ce = 1'b1;
        chk("ce_lat", longint'(lat), 36);
        chk("ce_dout", longint'($signed(dout)), 10000);
        chk("ce_ovf", longint'(ovf), 0);
        @(posedge clk);
        @(negedge clk);
        chk("ce_accepted", longint'(dout_valid), 0);
        dout_ready = 1'b0;

        // reset at CALC step 12 (with ce low, reset still wins)
        din0      = 30'd1000000;
        din1      = 16'd100;
        din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", longint'(din_ready), 0);
        reset = 1'b1;
        ce    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ce    = 1'b1;
        chk("midrst_valid", longint'(dout_valid), 0);
        chk("midrst_ready", longint'(din_ready), 1);
        chk("midrst_dout", longint'(dout), 0);
        dout_ready = 1'b1;
        spur = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (dout_valid) spur++;
        end
        chk("midrst_no_result", longint'(spur), 0);
        do_op(30'd100, 16'd7, 0, q, o, z, r, lat);
        chk("after_rst_q", q, 14);
        chk("after_rst_ovf", o, 0);
        chk("after_rst_lat", longint'(lat), 31);
`ifdef NETWORK_DIV_REMAINDER_EN
        chk("after_rst_rem", r, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
